// File: rtl/sprite_blitter.sv
// Streams a SPRITE_W x SPRITE_H sprite from a shared image ROM to a VGA pixel-write port,
// one pixel per clock, with frame select, horizontal mirroring, colour keying and edge clipping.
module sprite_blitter #(
   parameter int SPRITE_W     = 32,
   parameter int SPRITE_H     = 32,
   parameter int FRAMES       = 4,
   parameter int SCREEN_W     = 160,
   parameter int SCREEN_H     = 120,
   parameter int POS_X_WIDTH  = 9,
   parameter int POS_Y_WIDTH  = 8,
   parameter int OUT_X_WIDTH  = 8,
   parameter int OUT_Y_WIDTH  = 7,
   parameter int COLOUR_WIDTH = 8,
   parameter int ADDR_WIDTH   = 14,
   parameter int ROM_LATENCY  = 1,
   parameter logic [COLOUR_WIDTH-1:0] TRANSPARENT = COLOUR_WIDTH'('hE3),
   parameter int FRAME_WIDTH  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [POS_X_WIDTH-1:0]  x_pos,
   input  logic [POS_Y_WIDTH-1:0]  y_pos,
   input  logic [FRAME_WIDTH-1:0]  frame,
   input  logic                    flip_x,
   output logic [ADDR_WIDTH-1:0]   rom_addr,
   input  logic [COLOUR_WIDTH-1:0] rom_q,
   output logic [OUT_X_WIDTH-1:0]  x_out,
   output logic [OUT_Y_WIDTH-1:0]  y_out,
   output logic [COLOUR_WIDTH-1:0] colour,
   output logic                    write_en,
   output logic                    busy,
   output logic                    done
);

   localparam int N     = SPRITE_W * SPRITE_H;
   localparam int COL_W = $clog2(SPRITE_W);
   localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int SX_W  = POS_X_WIDTH + 1;
   localparam int SY_W  = POS_Y_WIDTH + 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic            v;
      logic [SX_W-1:0] sx;
      logic [SY_W-1:0] sy;
   } pix_t;

   state_t                   r_state, w_next;
   logic [POS_X_WIDTH-1:0]   r_x_pos;
   logic [POS_Y_WIDTH-1:0]   r_y_pos;
   logic [FRAME_WIDTH-1:0]   r_frame;
   logic                     r_flip;
   logic [COL_W-1:0]         r_col;
   logic [ROW_W-1:0]         r_row;
   logic [CNT_W-1:0]         r_drain_cnt;
   logic                     r_out_v;
   logic [SX_W-1:0]          r_sx;
   logic [SY_W-1:0]          r_sy;
   logic [COLOUR_WIDTH-1:0]  r_colour;

   logic                     w_accept, w_last_col, w_last_pix, w_on_screen;
   logic [FRAME_WIDTH-1:0]   w_frame;
   logic [COL_W-1:0]         w_c;
   pix_t                     w_in, w_last_in;

   // The DONE cycle may accept a new request so back-to-back draws lose no clock.
   assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last_col = (r_col == COL_W'(SPRITE_W - 1));
   assign w_last_pix = w_last_col && (r_row == ROW_W'(SPRITE_H - 1));
   assign w_frame    = ({1'b0, frame} >= (FRAME_WIDTH + 1)'(FRAMES)) ? FRAME_WIDTH'(FRAMES - 1) : frame;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      // NOTE: default first, so no path through the case can infer a latch.
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last_pix) w_next = S_DRAIN;
         S_DRAIN: if (r_drain_cnt == CNT_W'(ROM_LATENCY - 1)) w_next = S_DONE;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_x_pos     <= '0;
         r_y_pos     <= '0;
         r_frame     <= '0;
         r_flip      <= 1'b0;
         r_col       <= '0;
         r_row       <= '0;
         r_drain_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_x_pos <= x_pos;
            r_y_pos <= y_pos;
            r_frame <= w_frame;
            r_flip  <= flip_x;
            r_col   <= '0;
            r_row   <= '0;
         end else if (r_state == S_RUN) begin
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) r_row <= r_row + 1'b1;
         end
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      end
   end

   assign w_c      = r_flip ? COL_W'(SPRITE_W - 1) - r_col : r_col;
   assign rom_addr = ADDR_WIDTH'(r_frame) * ADDR_WIDTH'(N)
                   + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(SPRITE_W)
                   + ADDR_WIDTH'(w_c);

   always_comb begin
      w_in.v  = (r_state == S_RUN);
      w_in.sx = SX_W'(r_x_pos) + SX_W'(r_col);
      w_in.sy = SY_W'(r_y_pos) + SY_W'(r_row);
   end

   // ROM_LATENCY-1 shift stages; the output register below is the final stage.
   generate
      if (ROM_LATENCY > 1) begin : g_pipe
         pix_t r_pipe [ROM_LATENCY-1];
         always_ff @(posedge clk) begin
            if (!resetn) begin
               // NOTE: only the valid bits matter, but clearing whole stages costs nothing here.
               for (int i = 0; i < ROM_LATENCY - 1; i++) r_pipe[i] <= '0;
            end else begin
               r_pipe[0] <= w_in;
               for (int i = 1; i < ROM_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_last_in = r_pipe[ROM_LATENCY-2];
      end else begin : g_direct
         assign w_last_in = w_in;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out_v  <= 1'b0;
         r_sx     <= '0;
         r_sy     <= '0;
         r_colour <= '0;
      end else begin
         r_out_v <= w_last_in.v;
         if (w_last_in.v) begin
            r_sx <= w_last_in.sx;
            r_sy <= w_last_in.sy;
         end
         if (r_out_v) r_colour <= rom_q;
      end
   end

   // rom_q lands in the presentation cycle itself; r_colour holds it once the pixel has passed.
   assign colour      = r_out_v ? rom_q : r_colour;
   assign x_out       = r_sx[OUT_X_WIDTH-1:0];
   assign y_out       = r_sy[OUT_Y_WIDTH-1:0];
   assign w_on_screen = (r_sx < SX_W'(SCREEN_W)) && (r_sy < SY_W'(SCREEN_H));
   assign write_en    = r_out_v && (rom_q != TRANSPARENT) && w_on_screen;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Drives two 4x2 blitters (ROM latency 1 and 3) with identical requests and checks every
// cycle of both against a per-cycle expectation queue built from a behavioural model.
module tb_sprite_blitter;

   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;

   typedef struct {
      int         cyc;
      logic       busy, done, chk_addr, chk_pix, we;
      logic [13:0] addr;
      logic [7:0] x;
      logic [6:0] y;
      logic [7:0] colour;
   } exp_t;

   typedef struct {
      int px, py, fr;
      bit fl, transp;
      int exp_wr;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn, start, flip_x;
   logic [8:0] x_pos;
   logic [7:0] y_pos;
   logic [1:0] frame;

   logic [13:0] addr0, addr1;
   logic [7:0]  rq0, rq1, co0, co1, xo0, xo1;
   logic [6:0]  yo0, yo1;
   logic        we0, we1, bz0, bz1, dn0, dn1;

   logic [7:0]  mem [64];
   logic [13:0] ap0 [1];
   logic [13:0] ap1 [3];

   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   vectors = 0;
   int   fails = 0;
   int   wr0 = 0, wr1 = 0;
   bit   mon_en = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .ROM_LATENCY(1)) dut_l1 (
      .clk(clk), .resetn(resetn), .start(start), .x_pos(x_pos), .y_pos(y_pos),
      .frame(frame), .flip_x(flip_x), .rom_addr(addr0), .rom_q(rq0), .x_out(xo0),
      .y_out(yo0), .colour(co0), .write_en(we0), .busy(bz0), .done(dn0));

   sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .ROM_LATENCY(3)) dut_l3 (
      .clk(clk), .resetn(resetn), .start(start), .x_pos(x_pos), .y_pos(y_pos),
      .frame(frame), .flip_x(flip_x), .rom_addr(addr1), .rom_q(rq1), .x_out(xo1),
      .y_out(yo1), .colour(co1), .write_en(we1), .busy(bz1), .done(dn1));

   // Shared ROM with a per-DUT read latency.
   always @(posedge clk) begin
      ap0[0] <= addr0;
      ap1[0] <= addr1;
      ap1[1] <= ap1[0];
      ap1[2] <= ap1[1];
   end
   assign rq0 = mem[ap0[0][5:0]];
   assign rq1 = mem[ap1[2][5:0]];

   function automatic int addr_of(input int k, input int fr, input bit fl);
      int col = k % W;
      int row = k / W;
      return fr * N + row * W + (fl ? W - 1 - col : col);
   endfunction

   task automatic set_rom(input bit transp);
      for (int a = 0; a < 64; a++) mem[a] = 8'(a + 16);
      if (transp) begin
         mem[1] = 8'hE3;
         mem[6] = 8'hE3;
      end
   endtask

   task automatic push_op(input int lat, input int e, input int px, input int py,
                          input int fr, input bit fl);
      exp_t r;
      int   k, sx, sy;
      for (int j = 1; j <= N + lat + 1; j++) begin
         r.cyc = e + j; r.busy = 1'b1; r.done = (j == N + lat + 1);
         r.chk_addr = (j <= N); r.addr = '0;
         if (j <= N) r.addr = 14'(addr_of(j - 1, fr, fl));
         k = j - 1 - lat;
         r.chk_pix = (k >= 0 && k < N);
         r.x = '0; r.y = '0; r.colour = '0; r.we = 1'b0;
         if (r.chk_pix) begin
            sx = px + k % W;
            sy = py + k / W;
            r.x = 8'(sx);
            r.y = 7'(sy);
            r.colour = mem[addr_of(k, fr, fl)];
            r.we = (r.colour != 8'hE3) && sx < 160 && sy < 120;
         end
         if (lat == 1) q0.push_back(r);
         else          q1.push_back(r);
      end
   endtask

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic mon(input int id, input logic [13:0] a, input logic [7:0] x, input logic [6:0] y,
                      input logic [7:0] c, input logic w, input logic b, input logic d);
      exp_t e;
      bit   have = 0, ok;
      if (id == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1; end
      if (id == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1; end
      if (w === 1'b1) begin
         if (id == 0) wr0++;
         else         wr1++;
      end
      vectors++;
      if (!have) ok = (w === 1'b0) && (b === 1'b0) && (d === 1'b0);
      else ok = (b === e.busy) && (d === e.done) && (w === e.we)
             && (!e.chk_addr || a === e.addr)
             && (!e.chk_pix || (x === e.x && y === e.y && c === e.colour));
      if (!ok) begin
         fails++;
         if (have)
            $display("FAIL dut%0d cyc %0d: got addr=%0d x=%0d y=%0d col=%h we=%b busy=%b done=%b; want addr=%0d(%b) x=%0d y=%0d col=%h(%b) we=%b busy=%b done=%b",
                     id, cyc, a, x, y, c, w, b, d, e.addr, e.chk_addr, e.x, e.y, e.colour, e.chk_pix,
                     e.we, e.busy, e.done);
         else
            $display("FAIL dut%0d cyc %0d idle: got we=%b busy=%b done=%b, want 0 0 0", id, cyc, w, b, d);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, addr0, xo0, yo0, co0, we0, bz0, dn0);
         mon(1, addr1, xo1, yo1, co1, we1, bz1, dn1);
      end
   end

   task automatic run_op(input int px, input int py, input int fr, input bit fl, output int e);
      @(negedge clk);
      wr0 = 0; wr1 = 0;
      x_pos = 9'(px); y_pos = 8'(py); frame = 2'(fr); flip_x = fl; start = 1'b1;
      e = cyc;
      push_op(1, e, px, py, fr, fl);
      push_op(3, e, px, py, fr, fl);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         vectors++;
         fails++;
         $display("FAIL timeout: %0d/%0d expectations left, want 0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      int   e;
      tbl[0] = '{10, 20, 0, 1'b0, 1'b0, 8};
      tbl[1] = '{10, 20, 2, 1'b1, 1'b0, 8};
      tbl[2] = '{10, 20, 0, 1'b0, 1'b1, 6};
      tbl[3] = '{0, 0, 3, 1'b1, 1'b0, 8};
      tbl[4] = '{157, 118, 1, 1'b0, 1'b0, 6};

      resetn = 1'b0; start = 1'b0; x_pos = '0; y_pos = '0; frame = '0; flip_x = 1'b0;
      set_rom(1'b0);
      repeat (3) @(negedge clk);
      check("reset addr", int'(addr0) + int'(addr1), 0);
      check("reset x_out", int'(xo0) + int'(xo1), 0);
      check("reset y_out", int'(yo0) + int'(yo1), 0);
      check("reset colour", int'(co0) + int'(co1), 0);
      check("reset we/busy/done", int'({we0, bz0, dn0, we1, bz1, dn1}), 0);
      resetn = 1'b1;
      mon_en = 1;

      for (int i = 0; i < 5; i++) begin
         set_rom(tbl[i].transp);
         run_op(tbl[i].px, tbl[i].py, tbl[i].fr, tbl[i].fl, e);
         wait_idle();
         check($sformatf("writes l1 vec%0d", i), wr0, tbl[i].exp_wr);
         check($sformatf("writes l3 vec%0d", i), wr1, tbl[i].exp_wr);
      end

      // Clip at the bottom-right corner with start held: restart only on the edge leaving DONE.
      set_rom(1'b0);
      @(negedge clk);
      wr0 = 0; wr1 = 0;
      x_pos = 9'd158; y_pos = 8'd119; frame = '0; flip_x = 1'b0; start = 1'b1;
      e = cyc;
      push_op(1, e, 158, 119, 0, 1'b0);
      push_op(1, e + N + 2, 158, 119, 0, 1'b0);
      push_op(3, e, 158, 119, 0, 1'b0);
      push_op(3, e + N + 4, 158, 119, 0, 1'b0);
      repeat (13) @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("clip writes l1", wr0, 4);
      check("clip writes l3", wr1, 4);

      // Reset during cycle E+4 aborts both draws with no done pulse.
      run_op(10, 20, 1, 1'b0, e);
      repeat (3) @(negedge clk);
      while (q0.size() > 0 && q0[$].cyc > e + 4) void'(q0.pop_back());
      while (q1.size() > 0 && q1[$].cyc > e + 4) void'(q1.pop_back());
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("abort x_out", int'(xo0) + int'(xo1), 0);
      check("abort colour", int'(co0) + int'(co1), 0);
      resetn = 1'b1;
      run_op(10, 20, 0, 1'b0, e);
      wait_idle();
      check("post-abort writes l1", wr0, 8);
      check("post-abort writes l3", wr1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
